// File: rtl/keypad_emu_b3.sv
// PmodKYPD keypad emulator: CPU-queued keycodes are played as press/release on the row lines.
// Optional contact bounce at the start of each press when KEYEMU_BOUNCE_EN is defined.
module keypad_emu_b3 #(
  parameter int HOLD_CYCLES   = 2_000_000,
  parameter int GAP_CYCLES    = 2_000_000,
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNCE_CYCLES = 50_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_addr,
  input  logic [7:0] i_data_in,
  input  logic       i_we,
  output logic [7:0] o_data_out,
  input  logic       i_re,
  input  logic [3:0] i_col,
  output logic [3:0] o_row
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) > 13) ? $clog2(MAXC + 1) : 13;

`ifdef KEYEMU_BOUNCE_EN
  localparam logic BOUNCE_EN = 1'b1;
`else
  localparam logic BOUNCE_EN = 1'b0;
`endif

  // state   | meaning
  // S_IDLE  | no key played; pops the next code when the FIFO is non-empty
  // S_PRESS | cur_key held down for HOLD_CYCLES
  // S_GAP   | all keys released for GAP_CYCLES
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [3:0]      r_cur_key;
  logic [3:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [CNTW-1:0] w_count_nxt;
  logic            r_ovf;
  logic [3:0]      r_row;
  logic [3:0]      w_row_nxt;

  logic            w_empty;
  logic            w_full;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_stat_rd;
  logic            w_busy;
  logic            w_in_bounce;
  logic            w_pressed;
  logic [1:0]      w_key_row;
  logic [1:0]      w_key_col;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNTW'(FIFO_DEPTH));
  assign w_push_req = i_we & ~i_addr;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push;
  assign w_stat_rd  = i_re & i_addr;
  assign w_busy     = (r_state != S_IDLE);

  assign w_in_bounce = (r_cnt < CW'(BOUNCE_CYCLES));
  assign w_pressed   = (r_state == S_PRESS) & (~BOUNCE_EN | ~w_in_bounce | r_cnt[12]);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS: begin
        if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == CW'(GAP_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cur_key <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) begin
        r_cur_key <= r_mem[r_rd_ptr];
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNTW'(1);
      2'b01:   w_count_nxt = r_count - CNTW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data_in[3:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // A dropped push in the same cycle as a STATUS read keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_stat_rd) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_key_row = 2'd0;
    w_key_col = 2'd0;
    case (r_cur_key)
      4'h1: begin w_key_row = 2'd0; w_key_col = 2'd0; end
      4'h2: begin w_key_row = 2'd0; w_key_col = 2'd1; end
      4'h3: begin w_key_row = 2'd0; w_key_col = 2'd2; end
      4'hA: begin w_key_row = 2'd0; w_key_col = 2'd3; end
      4'h4: begin w_key_row = 2'd1; w_key_col = 2'd0; end
      4'h5: begin w_key_row = 2'd1; w_key_col = 2'd1; end
      4'h6: begin w_key_row = 2'd1; w_key_col = 2'd2; end
      4'hB: begin w_key_row = 2'd1; w_key_col = 2'd3; end
      4'h7: begin w_key_row = 2'd2; w_key_col = 2'd0; end
      4'h8: begin w_key_row = 2'd2; w_key_col = 2'd1; end
      4'h9: begin w_key_row = 2'd2; w_key_col = 2'd2; end
      4'hC: begin w_key_row = 2'd2; w_key_col = 2'd3; end
      4'h0: begin w_key_row = 2'd3; w_key_col = 2'd0; end
      4'hF: begin w_key_row = 2'd3; w_key_col = 2'd1; end
      4'hE: begin w_key_row = 2'd3; w_key_col = 2'd2; end
      4'hD: begin w_key_row = 2'd3; w_key_col = 2'd3; end
      default: begin w_key_row = 2'd0; w_key_col = 2'd0; end
    endcase
  end

  always_comb begin
    w_row_nxt = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      w_row_nxt[r] = ~(w_pressed & (w_key_row == 2'(r)) & ~i_col[w_key_col]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row <= 4'b1111;
    end else begin
      r_row <= w_row_nxt;
    end
  end

  assign o_row = r_row;

  always_comb begin
    o_data_out = 8'h00;
    if (i_re) begin
      if (i_addr) begin
        o_data_out = {w_busy, r_ovf, w_full, w_empty, 1'b0, 3'(r_count)};
      end else if (w_busy) begin
        o_data_out = {4'b0000, r_cur_key};
      end
    end
  end

endmodule

// File: tb/tb_keypad_emu_b3.sv
// Directed bench for keypad_emu_b3 with HOLD=8, GAP=4, FIFO_DEPTH=4, bounce disabled.
module tb_keypad_emu_b3;

  logic       clk = 1'b0;
  logic       reset;
  logic       addr;
  logic [7:0] din;
  logic       we;
  logic [7:0] dout;
  logic       re;
  logic [3:0] col;
  logic [3:0] row;
  logic [7:0] v;
  int         n_chk = 0;
  int         n_err = 0;

  keypad_emu_b3 #(
    .HOLD_CYCLES(8),
    .GAP_CYCLES(4),
    .FIFO_DEPTH(4),
    .BOUNCE_CYCLES(2)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_addr(addr),
    .i_data_in(din),
    .i_we(we),
    .o_data_out(dout),
    .i_re(re),
    .i_col(col),
    .o_row(row)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] code);
    we = 1'b1; addr = 1'b0; din = {4'h0, code};
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [7:0] val);
    re = 1'b1; addr = a;
    #1;
    val = dout;
    re = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] s;
    s = 8'hFF;
    for (int k = 0; k < 60; k++) begin
      rd(1'b1, s);
      if (!s[7]) break;
      tick();
    end
    check(tag, {7'b0, s[7]}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = 1'b0; din = 8'h00; col = 4'hF;
    repeat (3) tick();
    check("rst_row", {4'h0, row}, 8'h0F);
    check("rst_dout", dout, 8'h00);
    rd(1'b1, v); check("rst_status", v, 8'h10);
    reset = 1'b0;
    tick();

    // single key 5 with col1 held low
    col = 4'b1101;
    wr(4'h5);
    rd(1'b1, v); check("t1_queued", v, 8'h01);
    tick();
    rd(1'b1, v); check("t1_press", v, 8'h90);
    check("t1_row_lag", {4'h0, row}, 8'h0F);
    tick();
    check("t1_row_low", {4'h0, row}, 8'h0D);
    repeat (7) tick();
    check("t1_row_last", {4'h0, row}, 8'h0D);
    tick();
    check("t1_row_rel", {4'h0, row}, 8'h0F);
    repeat (2) tick();
    rd(1'b1, v); check("t1_gap_busy", v, 8'h90);
    tick();
    rd(1'b1, v); check("t1_idle", v, 8'h10);

    // key D, sweep columns
    col = 4'b1110;
    wr(4'hD);
    tick();
    tick();
    check("t2_c0", {4'h0, row}, 8'h0F);
    col = 4'b1101; tick();
    check("t2_c1", {4'h0, row}, 8'h0F);
    col = 4'b1011; tick();
    check("t2_c2", {4'h0, row}, 8'h0F);
    col = 4'b0111;
    check("t2_lag", {4'h0, row}, 8'h0F);
    tick();
    check("t2_c3", {4'h0, row}, 8'h07);
    col = 4'b1110; tick();
    check("t2_c0b", {4'h0, row}, 8'h0F);
    wait_idle("t2_idle_wait");

    // fill FIFO, overflow, read-to-clear
    for (int i = 1; i <= 5; i++) wr(4'(i));
    rd(1'b1, v); check("t3_full", v, 8'hA4);
    wr(4'h6);
    rd(1'b1, v); check("t3_ovf", v, 8'hE4);
    re = 1'b1; addr = 1'b1;
    #1;
    check("t3_ovf_rd", dout, 8'hE4);
    tick();
    re = 1'b0;
    rd(1'b1, v); check("t3_ovf_clr", v, 8'hA4);
    rd(1'b0, v); check("t3_key1", v, 8'h01);

    // push into full FIFO on the pop cycle
    v = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      rd(1'b1, v);
      if (!v[7]) break;
      tick();
    end
    check("t4_idle_full", v, 8'h24);
    wr(4'h6);
    rd(1'b1, v); check("t4_push_ok", v, 8'hA4);
    rd(1'b0, v); check("t4_key2", v, 8'h02);

    // reset mid-press with two keys queued
    reset = 1'b1; tick(); reset = 1'b0; tick();
    col = 4'b1110;
    wr(4'h7); wr(4'h8); wr(4'h9);
    check("t5_row7", {4'h0, row}, 8'h0B);
    rd(1'b1, v); check("t5_pre", v, 8'h82);
    reset = 1'b1;
    tick();
    check("t5_row", {4'h0, row}, 8'h0F);
    rd(1'b1, v); check("t5_status", v, 8'h10);
    rd(1'b0, v); check("t5_key", v, 8'h00);
    check("t5_dout", dout, 8'h00);
    reset = 1'b0;
    tick();
    rd(1'b1, v); check("t5_flushed", v, 8'h10);

    // KEY register reads across PRESS/GAP/IDLE; re=0 gating
    col = 4'b0111;
    wr(4'hA);
    addr = 1'b1; #1; check("t6_re0_a1", dout, 8'h00);
    tick();
    rd(1'b0, v); check("t6_key_press", v, 8'h0A);
    addr = 1'b0; #1; check("t6_re0_a0", dout, 8'h00);
    tick();
    check("t6_rowA", {4'h0, row}, 8'h0E);
    repeat (7) tick();
    rd(1'b1, v); check("t6_gap", v, 8'h90);
    rd(1'b0, v); check("t6_key_gap", v, 8'h0A);
    wait_idle("t6_idle_wait");
    rd(1'b0, v); check("t6_key_idle", v, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
